// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small byte FIFO.
// TXDATA at BASE_ADDR, STATUS at BASE_ADDR+1; rdata is zero on a miss.
module mmio_uart_tx #(
    parameter logic [29:0] BASE_ADDR    = 30'h3FFFFFF0,
    parameter int          CLKS_PER_BIT = 104,
    parameter int          FIFO_AW      = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [29:0] addr,
    input  logic [31:0] wdata,
    input  logic        re,
    input  logic        we,
    output logic [31:0] rdata,
    output logic        tx
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C =
        (FIFO_AW+1)'(DEPTH);
    localparam logic [15:0] BAUD_LAST =
        16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state;
    logic [15:0]        baud_cnt;
    logic [2:0]         bit_idx;
    logic [7:0]         shift;

    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW:0]   count;
    logic               overflow;

    logic               hit_data;
    logic               hit_stat;
    logic               full;
    logic               empty;
    logic               busy;
    logic               push;
    logic               drop;
    logic               pop;
    logic               baud_end;
    logic               stat_rd;
    logic [31:0]        status;

    logic               unused_wdata;
    assign unused_wdata = ^wdata[31:8];

    assign hit_data = (addr == BASE_ADDR);
    assign hit_stat = (addr == BASE_ADDR + 30'd1);
    assign full     = (count == DEPTH_C);
    assign empty    = (count == '0);
    assign busy     = (state != IDLE);
    assign push     = we & hit_data & ~full;
    assign drop     = we & hit_data & full;
    assign stat_rd  = re & hit_stat;
    assign baud_end = (baud_cnt == BAUD_LAST);

    // The FSM consumes a byte when idle or at the last stop-bit cycle.
    assign pop = ~empty &
                 ((state == IDLE) |
                  ((state == STOP) & baud_end));

    // Status word as seen by firmware.
    always_comb begin
        status                = '0;
        status[0]             = full;
        status[1]             = empty;
        status[2]             = busy;
        status[3]             = overflow;
        status[8+FIFO_AW:8]   = count;
    end

    // FIFO storage; contents need no reset since count guards reads.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata[7:0];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a dropped write wins over a clearing read.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (stat_rd) begin
            overflow <= 1'b0;
        end
    end

    // Registered read port, one cycle like synchronous RAM.
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else begin
            rdata <= stat_rd ? status : 32'd0;
        end
    end

    // Bit-timer FSM; tx is registered so it trails state by a cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx       <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (pop) begin
                        shift    <= mem[rd_ptr];
                        baud_cnt <= '0;
                        state    <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                DATA: begin
                    tx <= shift[0];
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shift    <= shift >> 1;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
